// File: rtl/cla_wide_add_seq_pkg.sv
// Shared definitions for the sequenced wide adder/subtractor.
//   SLICE_W : width of the shared carry-lookahead adder slice
//   state_t : controller state encoding
package cla_wide_add_seq_pkg;

    localparam int unsigned SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add16_slice.sv
// Combinational 16-bit carry-lookahead adder: four 4-bit groups with a
// second lookahead level across the group generate/propagate terms.
//   a, b : addends
//   ci   : carry in
//   s    : sum
//   co   : carry out of bit 15
module add16_slice
    import cla_wide_add_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] c;
    logic [3:0]         gg;
    logic [3:0]         gp;
    logic [3:0]         gc;

    // Bit and group generate/propagate, group carries, then bit carries.
    always_comb begin
        g  = a & b;
        p  = a ^ b;
        gg = '0;
        gp = '0;
        c  = '0;

        for (int j = 0; j < 4; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end

        gc[0] = ci;
        gc[1] = gg[0] | (gp[0] & ci);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & ci);
        co    = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & ci);

        for (int j = 0; j < 4; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])
                     | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                     | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end

        s = p ^ c;
    end

endmodule

// File: rtl/cla_wide_add_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor. One shared 16-bit CLA slice is
// applied LS slice first over WIDTH/16 cycles with the carry chained
// through a register.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : operand handshake (a, b, cin, sub)
//   out_valid/out_ready  : result handshake (sum, cout, ovf)
//   sub=1 computes a-b (cin ignored); cout=1 then means no borrow
module cla_wide_add_seq
    import cla_wide_add_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
        $error("cla_wide_add_seq: WIDTH must be a multiple of 16 and at least 16");
    end

    typedef logic [NSLICE-1:0][SLICE_W-1:0] slices_t;

    state_t           state_q, state_d;
    slices_t          a_q, a_d;
    slices_t          b_q, b_d;
    slices_t          sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cout_d, ovf_d;
    logic             in_ready_d, out_valid_d;

    logic [SLICE_W-1:0] slice_s;
    logic               slice_co;
    logic               last_slice;

    // Single shared adder; operand slice chosen by the pass counter.
    add16_slice u_slice (
        .a  (a_q[cnt_q]),
        .b  (b_q[cnt_q]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    assign last_slice = (cnt_q == CNT_W'(NSLICE - 1));
    assign sum        = sum_q;

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        cout_d  = cout;
        ovf_d   = ovf;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    a_d     = a;
                    // Subtraction as a + ~b + 1.
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                sum_d[cnt_q] = slice_s;
                carry_d      = slice_co;
                if (last_slice) begin
                    state_d = DONE;
                    cout_d  = slice_co;
                    ovf_d   = (a_q[NSLICE-1][SLICE_W-1] == b_q[NSLICE-1][SLICE_W-1])
                           && (slice_s[SLICE_W-1] != a_q[NSLICE-1][SLICE_W-1]);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            cout      <= cout_d;
            ovf       <= ovf_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_cla_wide_add_seq.sv
// Directed bench for cla_wide_add_seq: a 64-bit instance checked every cycle
// against an arithmetic model, plus a 16-bit instance for the single-pass case.
module tb_cla_wide_add_seq;

    localparam int NS = 4;

    typedef struct packed {
        logic [63:0] s;
        logic        co;
        logic        ov;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0, sub = 1'b0;
    logic [63:0] a = '0, b = '0;
    logic        in_ready, out_valid, cout, ovf;
    logic [63:0] sum;

    logic        in_valid16 = 1'b0, out_ready16 = 1'b0, cin16 = 1'b0, sub16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        in_ready16, out_valid16, cout16, ovf16;
    logic [15:0] sum16;

    int cmp_n = 0;
    int err_n = 0;

    int   m_phase = 0;
    res_t m_exp   = '0;

    always #5 clk = ~clk;

    cla_wide_add_seq #(.WIDTH(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    cla_wide_add_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin16), .sub(sub16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Signed/unsigned arithmetic reference for a 64-bit operation.
    function automatic res_t model(input logic [63:0] x, input logic [63:0] y,
                                   input logic c, input logic s);
        res_t               r;
        logic signed [65:0] sx, sy, sr;
        logic        [64:0] u;
        sx = {{2{x[63]}}, x};
        sy = {{2{y[63]}}, y};
        if (s) begin
            sr   = sx - sy;
            r.s  = x - y;
            r.co = (x >= y);
        end else begin
            sr   = sx + sy + 66'(c);
            u    = {1'b0, x} + {1'b0, y} + 65'(c);
            r.s  = u[63:0];
            r.co = u[64];
        end
        r.ov = (sr != {{2{sr[63]}}, sr[63:0]});
        return r;
    endfunction

    // Model: phase 0 idle, 1..NS computing, NS+1 result offered.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                m_exp   <= model(a, b, cin, sub);
                m_phase <= 1;
            end
        end else if (m_phase <= NS) begin
            m_phase <= m_phase + 1;
        end else if (out_ready) begin
            m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", 64'(in_ready), 64'(m_phase == 0));
        chk("out_valid", 64'(out_valid), 64'(m_phase == NS + 1));
        if (m_phase == NS + 1) begin
            chk("sum", sum, m_exp.s);
            chk("cout", 64'(cout), 64'(m_exp.co));
            chk("ovf", 64'(ovf), 64'(m_exp.ov));
        end
    end

    // One 64-bit operation; bp = cycles of held-off out_ready with in_valid high.
    task automatic do_op(input string name, input logic [63:0] ta, input logic [63:0] tb,
                         input logic tc, input logic ts, input int bp,
                         output res_t r);
        int waits;
        int edges;
        waits = 0;
        while (in_ready !== 1'b1 && waits < 20) begin
            @(posedge clk); #1; waits++;
        end
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges = 1;
        while (out_valid !== 1'b1 && edges < 20) begin
            @(posedge clk); #1; edges++;
        end
        chk({name, "_latency"}, 64'(edges), 64'(NS + 1));
        r.s = sum; r.co = cout; r.ov = ovf;
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'b1; a = '1; b = '1;
            @(posedge clk); #1;
            chk({name, "_bp_hold"}, 64'(out_valid), 64'(1));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({name, "_ready_after_hs"}, 64'(in_ready), 64'(1));
    endtask

    task automatic do16(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                        input logic [15:0] es, input logic eco, input logic eov);
        int edges;
        a16 = ta; b16 = tb; sub16 = ts; cin16 = 1'b0; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        edges = 1;
        while (out_valid16 !== 1'b1 && edges < 20) begin
            @(posedge clk); #1; edges++;
        end
        chk("w16_latency", 64'(edges), 64'(2));
        chk("w16_sum", 64'(sum16), 64'(es));
        chk("w16_cout", 64'(cout16), 64'(eco));
        chk("w16_ovf", 64'(ovf16), 64'(eov));
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        out_ready16 = 1'b0;
        chk("w16_ready_after_hs", 64'(in_ready16), 64'(1));
    endtask

    initial begin
        res_t r;

        // Hand-computed anchors for the model itself.
        r = model(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        chk("model_wrap", {r.s[61:0], r.co, r.ov}, {62'd0, 1'b1, 1'b0});
        r = model(64'd5, 64'd7, 1'b0, 1'b1);
        chk("model_borrow", r.s, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("model_borrow_co", 64'(r.co), 64'(0));
        r = model(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        chk("model_ovf", 64'(r.ov), 64'(1));
        r = model(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
        chk("model_ovf_sub", 64'(r.ov), 64'(1));

        #1 rst = 1'b1;
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_sum", sum, 64'd0);
        chk("rst_cout_ovf", {62'd0, cout, ovf}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        do_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, r);
        chk("wrap_sum", r.s, 64'd0);
        chk("wrap_flags", {62'd0, r.co, r.ov}, 64'b10);

        do_op("sub_5_7", 64'd5, 64'd7, 1'b0, 1'b1, 3, r);
        chk("sub_5_7_sum", r.s, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("sub_5_7_flags", {62'd0, r.co, r.ov}, 64'b00);

        // cin must be ignored for subtraction
        do_op("sub_7_5", 64'd7, 64'd5, 1'b1, 1'b1, 0, r);
        chk("sub_7_5_sum", r.s, 64'd2);
        chk("sub_7_5_flags", {62'd0, r.co, r.ov}, 64'b10);

        do_op("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1, r);
        chk("ovf_add_sum", r.s, 64'h8000_0000_0000_0000);
        chk("ovf_add_flags", {62'd0, r.co, r.ov}, 64'b01);

        do_op("ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 0, r);
        chk("ovf_sub_sum", r.s, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("ovf_sub_flags", {62'd0, r.co, r.ov}, 64'b11);

        // Reset after two compute passes discards the partial result.
        a = 64'h1234_5678_9ABC_DEF0; b = 64'd1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_sum", sum, 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_in_ready_rel", 64'(in_ready), 64'(1));

        do16(16'd3, 16'd4, 1'b0, 16'd7, 1'b0, 1'b0);
        do16(16'h8000, 16'd1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Carry crossing slice boundaries.
        do_op("chain", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b1, 1'b0, 0, r);
        chk("chain_sum", r.s, 64'h0001_0000_0001_0001);
        chk("chain_flags", {62'd0, r.co, r.ov}, 64'b00);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", cmp_n);
        $fatal(1, "timeout");
    end

endmodule
